intr_ctrl: RTL and testbench

Vectored interrupt controller sitting directly upstream of the pipelined CPU's interrupt port. It collects up to `N_SRC` external request lines, synchronises and edge-detects them, holds them as pending, and applies a software mask and fixed priority. It drives the CPU's single `intr` line and completes the `inta` acknowledge handshake by latching the winning source ID. It exposes a 4-word memory-mapped register window on the CPU data bus, so the handler can read the vector and signal end-of-interrupt.

---
 rtl/intr_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_intr_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Vectored interrupt controller: synchronised rising-edge requests, software mask,
// fixed lowest-index priority, inta handshake and a 4-word register window.
//
// state    | meaning
// IDLE     | no request presented to the CPU
// REQ      | intr high, waiting for inta (or for the request to be withdrawn)
// SERVICE  | handler running, intr held low until an EOI write
module intr_ctrl #(
    parameter int unsigned N_SRC = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [N_SRC-1:0] irq,
    input  logic             inta,
    output logic             intr,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] A_PENDING = 2'd0;
    localparam logic [1:0] A_MASK    = 2'd1;
    localparam logic [1:0] A_VECTOR  = 2'd2;
    localparam logic [1:0] A_EOI     = 2'd3;

    logic [N_SRC-1:0] sync1_q, sync1_d;
    logic [N_SRC-1:0] sync2_q, sync2_d;
    logic [N_SRC-1:0] prev_q, prev_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [4:0]       vec_id_q, vec_id_d;
    logic             vec_valid_q, vec_valid_d;
    logic             intr_q, intr_d;
    logic [31:0]      rdata_q, rdata_d;
    state_t           state_q, state_d;

    logic [N_SRC-1:0] irq_edge;
    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] win_oh;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] w1c_clr;
    logic [4:0]       win_id;
    logic             req;
    logic             bus_wr;
    logic             bus_rd;
    logic             eoi_wr;
    logic [31:0]      rd_val;
    logic             unused_wdata;

    assign unused_wdata = ^wdata[31:N_SRC];

    assign sync1_d  = irq;
    assign sync2_d  = sync1_q;
    assign prev_d   = sync2_q;
    assign irq_edge = sync2_q & ~prev_q;

    assign bus_wr = sel & we;
    assign bus_rd = sel & ~we;
    assign eoi_wr = bus_wr && (addr == A_EOI);

    // Arbitration always sees the registered pending/mask, i.e. pre-write values.
    assign active = pending_q & mask_q;
    assign req    = |active;

    always_comb begin
        win_id = '0;
        win_oh = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_id    = 5'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        intr_d      = intr_q;
        vec_id_d    = vec_id_q;
        vec_valid_d = vec_valid_q;
        ack_clr     = '0;
        case (state_q)
            ST_IDLE: begin
                intr_d = 1'b0;
                if (req) begin
                    state_d = ST_REQ;
                    intr_d  = 1'b1;
                end
            end
            ST_REQ: begin
                if (inta) begin
                    state_d = ST_SERVICE;
                    intr_d  = 1'b0;
                    if (req) begin
                        vec_id_d    = win_id;
                        vec_valid_d = 1'b1;
                        ack_clr     = win_oh;
                    end else begin
                        vec_id_d    = '0;
                        vec_valid_d = 1'b0;
                    end
                end else if (!req) begin
                    state_d = ST_IDLE;
                    intr_d  = 1'b0;
                end
            end
            ST_SERVICE: begin
                intr_d = 1'b0;
                if (eoi_wr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                intr_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w1c_clr = '0;
        mask_d  = mask_q;
        if (bus_wr && (addr == A_PENDING)) begin
            w1c_clr = wdata[N_SRC-1:0];
        end
        if (bus_wr && (addr == A_MASK)) begin
            mask_d = wdata[N_SRC-1:0];
        end
        // A new edge wins over a same-cycle clear of the same bit.
        pending_d = (pending_q & ~(ack_clr | w1c_clr)) | irq_edge;
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            A_PENDING: rd_val = 32'(pending_q);
            A_MASK:    rd_val = 32'(mask_q);
            A_VECTOR:  rd_val = {vec_valid_q, 26'd0, vec_id_q};
            A_EOI:     rd_val = '0;
            default:   rd_val = '0;
        endcase
        rdata_d = bus_rd ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            vec_id_q    <= '0;
            vec_valid_q <= 1'b0;
            intr_q      <= 1'b0;
            rdata_q     <= '0;
            state_q     <= ST_IDLE;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            vec_id_q    <= vec_id_d;
            vec_valid_q <= vec_valid_d;
            intr_q      <= intr_d;
            rdata_q     <= rdata_d;
            state_q     <= state_d;
        end
    end

    assign intr  = intr_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: latency, priority, masking, withdraw/spurious
// acknowledge, level-hold and mid-operation reset, all against hand-computed values.
module tb_intr_ctrl;

    localparam logic [1:0] A_PENDING = 2'd0;
    localparam logic [1:0] A_MASK    = 2'd1;
    localparam logic [1:0] A_VECTOR  = 2'd2;
    localparam logic [1:0] A_EOI     = 2'd3;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [7:0]  irq = '0;
    logic        inta = 1'b0;
    logic        intr;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_bad = 0;

    intr_ctrl #(.N_SRC(8)) dut (
        .clk   (clk),
        .clrn  (clrn),
        .irq   (irq),
        .inta  (inta),
        .intr  (intr),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        sel = 1'b1; we = 1'b0; addr = a;
        tick();
        d = rdata;
        sel = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    task automatic pulse_inta();
        inta = 1'b1;
        tick();
        inta = 1'b0;
    endtask

    task automatic wait_intr(input string tag, input int budget);
        int n = 0;
        while (!intr && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(intr), 32'd1);
    endtask

    initial begin
        int n_hi;
        int n_req;
        logic [31:0] held;

        ticks(3);
        chk("rst_intr", 32'(intr), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        clrn = 1'b1;
        tick();
        read_chk("rst_pending", A_PENDING, 32'h0);
        read_chk("rst_mask", A_MASK, 32'h0);
        read_chk("rst_vector", A_VECTOR, 32'h0);

        // single source: latency k+3
        bus_write(A_MASK, 32'h08);
        irq[3] = 1'b1;
        tick();
        chk("lat_k", 32'(intr), 32'd0);
        tick();
        chk("lat_k1", 32'(intr), 32'd0);
        tick();
        chk("lat_k2", 32'(intr), 32'd0);
        tick();
        chk("lat_k3", 32'(intr), 32'd1);
        read_chk("single_pend", A_PENDING, 32'h08);
        pulse_inta();
        chk("single_ack_intr", 32'(intr), 32'd0);
        read_chk("single_vec", A_VECTOR, 32'h8000_0003);
        tick();
        chk("rdata_hold", rdata, 32'h8000_0003);
        read_chk("single_pend_clr", A_PENDING, 32'h0);
        read_chk("single_mask", A_MASK, 32'h08);
        bus_write(A_EOI, 32'h0);
        ticks(4);
        chk("single_after_eoi", 32'(intr), 32'd0);
        irq[3] = 1'b0;

        // priority
        bus_write(A_MASK, 32'hFF);
        irq[5] = 1'b1; irq[2] = 1'b1;
        wait_intr("prio_intr", 8);
        pulse_inta();
        read_chk("prio_vec_a", A_VECTOR, 32'h8000_0002);
        read_chk("prio_pend_a", A_PENDING, 32'h20);
        pulse_inta();
        read_chk("service_inta_vec", A_VECTOR, 32'h8000_0002);
        read_chk("service_inta_pend", A_PENDING, 32'h20);
        bus_write(A_EOI, 32'h0);
        chk("prio_eoi_e", 32'(intr), 32'd0);
        tick();
        chk("prio_eoi_e1", 32'(intr), 32'd1);
        pulse_inta();
        read_chk("prio_vec_b", A_VECTOR, 32'h8000_0005);
        read_chk("prio_pend_b", A_PENDING, 32'h0);
        bus_write(A_EOI, 32'h0);
        irq[5] = 1'b0; irq[2] = 1'b0;
        ticks(3);

        // masked source
        bus_write(A_MASK, 32'h0);
        irq[1] = 1'b1;
        ticks(4);
        read_chk("mask_pend", A_PENDING, 32'h02);
        n_hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (intr) n_hi++;
        end
        chk("mask_quiet", 32'(n_hi), 32'd0);
        bus_write(A_MASK, 32'h02);
        chk("mask_w", 32'(intr), 32'd0);
        tick();
        chk("mask_w1", 32'(intr), 32'd1);
        pulse_inta();
        read_chk("mask_vec", A_VECTOR, 32'h8000_0001);
        bus_write(A_EOI, 32'h0);
        irq[1] = 1'b0;

        // withdraw by W1C
        bus_write(A_MASK, 32'h10);
        irq[4] = 1'b1;
        wait_intr("wd_intr", 8);
        bus_write(A_PENDING, 32'h10);
        chk("wd_c", 32'(intr), 32'd1);
        tick();
        chk("wd_c1", 32'(intr), 32'd0);
        ticks(3);
        chk("wd_idle", 32'(intr), 32'd0);
        read_chk("wd_pend", A_PENDING, 32'h0);

        // spurious acknowledge: W1C, then inta while FSM still in REQ
        irq[4] = 1'b0;
        ticks(4);
        irq[4] = 1'b1;
        wait_intr("sp_intr", 8);
        bus_write(A_PENDING, 32'h10);
        pulse_inta();
        chk("sp_ack_intr", 32'(intr), 32'd0);
        read_chk("sp_vec", A_VECTOR, 32'h0);
        irq[4] = 1'b0;
        ticks(4);
        irq[4] = 1'b1;
        n_hi = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (intr) n_hi++;
        end
        chk("sp_no_eoi_quiet", 32'(n_hi), 32'd0);
        read_chk("sp_pend", A_PENDING, 32'h10);
        bus_write(A_EOI, 32'h0);
        chk("sp_eoi_e", 32'(intr), 32'd0);
        tick();
        chk("sp_eoi_e1", 32'(intr), 32'd1);
        pulse_inta();
        read_chk("sp_vec2", A_VECTOR, 32'h8000_0004);
        bus_write(A_EOI, 32'h0);
        irq[4] = 1'b0;

        // level hold: one request only
        bus_write(A_MASK, 32'h01);
        irq[0] = 1'b1;
        n_req = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (intr) begin
                n_req++;
                pulse_inta();
                bus_write(A_EOI, 32'h0);
            end
        end
        chk("level_reqs", 32'(n_req), 32'd1);
        read_chk("level_vec", A_VECTOR, 32'h8000_0000);
        read_chk("level_pend", A_PENDING, 32'h0);
        irq[0] = 1'b0;
        ticks(3);

        // reset mid-REQ
        bus_write(A_MASK, 32'h40);
        irq[6] = 1'b1;
        wait_intr("rst2_intr", 8);
        bus_read(A_MASK, held);
        irq[6] = 1'b0;
        #2;
        clrn = 1'b0;
        #1;
        chk("rst2_async_intr", 32'(intr), 32'd0);
        chk("rst2_async_rdata", rdata, 32'd0);
        ticks(2);
        clrn = 1'b1;
        tick();
        chk("rst2_intr", 32'(intr), 32'd0);
        read_chk("rst2_pending", A_PENDING, 32'h0);
        read_chk("rst2_mask", A_MASK, 32'h0);
        read_chk("rst2_vector", A_VECTOR, 32'h0);
        ticks(5);
        chk("rst2_quiet", 32'(intr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
